// File: rtl/if_id_skid_pkg.sv
// Shared constants for the IF/ID boundary: default widths, the NOP encoding
// driven on an empty stage, and the occupancy helper.
package if_id_skid_pkg;

    localparam int unsigned ADDR_W_DEF   = 32;
    localparam int unsigned INST_W_DEF   = 32;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] ZERO_32      = 32'h0000_0000;

    // Entries held: main valid plus skid valid, never more than 2.
    function automatic logic [1:0] occ_sum(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/if_id_skid.sv
// IF->ID pipeline boundary: main output register plus one skid entry so that
// in_ready can be registered (no combinational path from out_ready/stall).
// Supports hazard stall and branch-resolution flush.
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int unsigned              ADDR_W   = ADDR_W_DEF,
    parameter int unsigned              INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0]        NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_pred,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_pred,
    output logic [1:0]        occupancy
);

    // Main (presented to decode) entry
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_pc;
    logic [INST_W-1:0] r_out_inst;
    logic              r_out_pred;

    // Skid entry
    logic              r_sk_valid;
    logic [ADDR_W-1:0] r_sk_pc;
    logic [INST_W-1:0] r_sk_inst;
    logic              r_sk_pred;

    logic              r_in_ready;

    // Handshake events and next-state values
    logic              w_acc;
    logic              w_cons;
    logic              w_main_load;
    logic              w_to_skid;

    logic              w_out_valid_nx;
    logic [ADDR_W-1:0] w_out_pc_nx;
    logic [INST_W-1:0] w_out_inst_nx;
    logic              w_out_pred_nx;
    logic              w_sk_valid_nx;
    logic [ADDR_W-1:0] w_sk_pc_nx;
    logic [INST_W-1:0] w_sk_inst_nx;
    logic              w_sk_pred_nx;

    assign w_acc       = in_valid & r_in_ready;
    assign w_cons      = r_out_valid & out_ready & ~stall;
    assign w_main_load = ~r_out_valid | w_cons;
    // in_ready is !skid_valid, so the "cons with skid full" refill case cannot
    // accept; the term is kept so the intent stays explicit.
    assign w_to_skid   = w_acc & ((r_out_valid & ~w_cons) | (w_cons & r_sk_valid));

    // Next-state selection: flush clears both entries, otherwise main refills
    // from skid first (FIFO order), then from the input.
    always_comb begin
        w_out_valid_nx = r_out_valid;
        w_out_pc_nx    = r_out_pc;
        w_out_inst_nx  = r_out_inst;
        w_out_pred_nx  = r_out_pred;
        w_sk_valid_nx  = r_sk_valid;
        w_sk_pc_nx     = r_sk_pc;
        w_sk_inst_nx   = r_sk_inst;
        w_sk_pred_nx   = r_sk_pred;

        if (flush) begin
            w_out_valid_nx = 1'b0;
            w_out_inst_nx  = NOP_INST;
            w_out_pred_nx  = 1'b0;
            w_sk_valid_nx  = 1'b0;
        end else begin
            if (w_main_load) begin
                if (r_sk_valid) begin
                    w_out_valid_nx = 1'b1;
                    w_out_pc_nx    = r_sk_pc;
                    w_out_inst_nx  = r_sk_inst;
                    w_out_pred_nx  = r_sk_pred;
                    w_sk_valid_nx  = 1'b0;
                end else if (w_acc) begin
                    w_out_valid_nx = 1'b1;
                    w_out_pc_nx    = in_pc;
                    w_out_inst_nx  = in_inst;
                    w_out_pred_nx  = in_pred;
                end else begin
                    w_out_valid_nx = 1'b0;
                    w_out_inst_nx  = NOP_INST;
                    w_out_pred_nx  = 1'b0;
                end
            end
            if (w_to_skid) begin
                w_sk_valid_nx = 1'b1;
                w_sk_pc_nx    = in_pc;
                w_sk_inst_nx  = in_inst;
                w_sk_pred_nx  = in_pred;
            end
        end
    end

    // State registers; in_ready is the registered complement of next skid valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= ADDR_W'(ZERO_32);
            r_out_inst  <= NOP_INST;
            r_out_pred  <= 1'b0;
            r_sk_valid  <= 1'b0;
            r_sk_pc     <= '0;
            r_sk_inst   <= NOP_INST;
            r_sk_pred   <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= w_out_valid_nx;
            r_out_pc    <= w_out_pc_nx;
            r_out_inst  <= w_out_inst_nx;
            r_out_pred  <= w_out_pred_nx;
            r_sk_valid  <= w_sk_valid_nx;
            r_sk_pc     <= w_sk_pc_nx;
            r_sk_inst   <= w_sk_inst_nx;
            r_sk_pred   <= w_sk_pred_nx;
            r_in_ready  <= ~w_sk_valid_nx;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;
    assign out_pred  = r_out_pred;
    assign occupancy = occ_sum(r_out_valid, r_sk_valid);

endmodule
